// File: rtl/my_pe_ctrl.sv
// Dot-product sequencer for one my_pe FMA element: fetch, prime, issue, then chain each issue on pe_dvalid.
// Latency 4 + len*L_pe to done; the PE paces progress through pe_dvalid, and each element aborts after TIMEOUT idle cycles.
module my_pe_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [DATA_WIDTH-1:0] b_rdata,
    output logic [DATA_WIDTH-1:0] pe_ain,
    output logic [DATA_WIDTH-1:0] pe_bin,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [DATA_WIDTH-1:0] pe_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRIME,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_k;
    logic [CW-1:0]         r_cnt;
    logic                  r_pf_pend;
    logic [DATA_WIDTH-1:0] r_ain;
    logic [DATA_WIDTH-1:0] r_bin;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_error;

    logic [ADDR_WIDTH:0]   w_k_next;
    logic [ADDR_WIDTH:0]   w_k_pf;
    logic                  w_multi;
    logic                  w_more;
    logic                  w_chain;
    logic                  w_last;
    logic                  w_timeout;
    logic                  w_pf_chain;

    // r_k is the element currently in flight in the PE; k+1 is the next issue, k+2 the next prefetch.
    assign w_k_next   = r_k + (ADDR_WIDTH + 1)'(1);
    assign w_k_pf     = r_k + (ADDR_WIDTH + 1)'(2);
    assign w_multi    = (r_len > (ADDR_WIDTH + 1)'(1));
    assign w_more     = (w_k_next < r_len);
    assign w_chain    = (r_state == S_WAIT) && pe_dvalid && w_more;
    assign w_last     = (r_state == S_WAIT) && pe_dvalid && !w_more;
    assign w_timeout  = (r_state == S_WAIT) && !pe_dvalid && (r_cnt == CW'(TIMEOUT - 1));
    assign w_pf_chain = w_chain && (w_k_pf < r_len);

    assign pe_ain = r_ain;
    assign pe_bin = r_bin;
    assign result = r_result;
    assign error  = r_error;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_FETCH;
            S_FETCH: w_next = S_PRIME;
            S_PRIME: w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_last || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        pe_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_en = 1'b1;
                busy   = 1'b1;
            end
            S_PRIME: busy = 1'b1;
            S_ISSUE: begin
                pe_valid = 1'b1;
                busy     = 1'b1;
                if (w_multi) begin
                    mem_en   = 1'b1;
                    mem_addr = ADDR_WIDTH'(1);
                end
            end
            S_WAIT: begin
                busy     = 1'b1;
                pe_valid = w_chain;
                if (w_pf_chain) begin
                    mem_en   = 1'b1;
                    mem_addr = w_k_pf[ADDR_WIDTH-1:0];
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_len     <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_pf_pend <= 1'b0;
            r_ain     <= '0;
            r_bin     <= '0;
            r_result  <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len    <= len;
                        r_k      <= '0;
                        r_result <= '0;
                        r_error  <= 1'b0;
                    end
                end
                S_PRIME: begin
                    r_ain <= a_rdata;
                    r_bin <= b_rdata;
                end
                S_ISSUE: begin
                    r_cnt     <= '0;
                    r_pf_pend <= w_multi;
                end
                S_WAIT: begin
                    // Prefetched data lands one cycle after its read; PE latency >= 2 keeps it ahead of the next issue.
                    if (r_pf_pend) begin
                        r_ain <= a_rdata;
                        r_bin <= b_rdata;
                    end
                    r_pf_pend <= w_pf_chain;
                    r_cnt     <= pe_dvalid ? '0 : r_cnt + CW'(1);
                    if (w_chain) r_k <= w_k_next;
                    if (w_last) r_result <= pe_dout;
                    if (w_timeout) r_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
